// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART word transmitter.
//   tx_state_t    : byte-level line states (IDLE, START, DATA, STOP)
//   DATA_BITS     : data bits per frame
//   clks_per_bit  : clock cycles per line bit, rounded to nearest
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int DATA_BITS = 8;

   function automatic int clks_per_bit(input longint freq, input longint baud);
      return int'((freq + baud / 2) / baud);
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: bit timer, START/DATA/STOP sequencing and the TxD register.
//   clk, rst   : clock and asynchronous active-high reset
//   byteStart  : load byteData and begin a frame (honoured only when idle)
//   byteData   : first byte of a word
//   lastByte   : the byte on the line is the final byte of its word
//   nextData   : byte to chain straight into the next frame when !lastByte
//   byteNext   : one-cycle pulse when a chained byte has been loaded
//   TxD        : serial line, idles high
//   busy       : high while a word is in flight
//   done       : one-cycle pulse when the last stop bit of the word ends
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int ClksPerBit = 4,
   parameter int StopBits   = 2
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 byteStart,
   input  logic [DATA_BITS-1:0] byteData,
   input  logic                 lastByte,
   input  logic [DATA_BITS-1:0] nextData,
   output logic                 byteNext,
   output logic                 TxD,
   output logic                 busy,
   output logic                 done
);

   localparam int TIMER_W = $clog2(ClksPerBit);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ClksPerBit - 1);
   localparam logic [2:0]         DATA_LAST  = 3'(DATA_BITS - 1);
   localparam logic [2:0]         STOP_LAST  = 3'(StopBits - 1);

   tx_state_t            state;
   logic [TIMER_W-1:0]   timer;
   logic [2:0]           bitCnt;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 txdReg;
   logic                 busyReg;
   logic                 doneReg;
   logic                 nextReg;
   logic                 bitEnd;

   assign bitEnd = (timer == TIMER_LAST);

   // TxD is always written with the value belonging to the state being
   // entered, so the line changes exactly on the bit boundary edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         timer    <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
         txdReg   <= 1'b1;
         busyReg  <= 1'b0;
         doneReg  <= 1'b0;
         nextReg  <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         nextReg <= 1'b0;
         case (state)
            IDLE: begin
               if (byteStart) begin
                  state    <= START;
                  timer    <= '0;
                  bitCnt   <= '0;
                  shiftReg <= byteData;
                  txdReg   <= 1'b0;
                  busyReg  <= 1'b1;
               end
            end
            START: begin
               if (bitEnd) begin
                  timer  <= '0;
                  bitCnt <= '0;
                  state  <= DATA;
                  txdReg <= shiftReg[0];
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            DATA: begin
               if (bitEnd) begin
                  timer <= '0;
                  if (bitCnt == DATA_LAST) begin
                     bitCnt <= '0;
                     state  <= STOP;
                     txdReg <= 1'b1;
                  end else begin
                     bitCnt   <= bitCnt + 3'd1;
                     shiftReg <= shiftReg >> 1;
                     txdReg   <= shiftReg[1];
                  end
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            STOP: begin
               if (bitEnd) begin
                  timer <= '0;
                  if (bitCnt == STOP_LAST) begin
                     bitCnt <= '0;
                     if (!lastByte) begin
                        // Chain directly into the next start bit: no gap cycle.
                        state    <= START;
                        shiftReg <= nextData;
                        txdReg   <= 1'b0;
                        nextReg  <= 1'b1;
                     end else begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                        doneReg <= 1'b1;
                     end
                  end else begin
                     bitCnt <= bitCnt + 3'd1;
                  end
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               txdReg  <= 1'b1;
               busyReg <= 1'b0;
            end
         endcase
      end
   end

   assign TxD      = txdReg;
   assign busy     = busyReg;
   assign done     = doneReg;
   assign byteNext = nextReg;

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a WordBytes-byte word over RS-232, byte 0 first,
// frames back to back (1 start, 8 data LSB first, StopBits stop, no parity).
//   clk, rst    : clock and asynchronous active-high reset
//   word_valid  : word_data is presented
//   word_ready  : block can accept a word (idle)
//   word_data   : word to send, byte 0 = bits [7:0]; captured on acceptance
//   TxD         : serial line, idles high
//   busy        : high while a word is in flight
//   done        : one-cycle pulse when the word's last stop bit completes
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int ClkFrequency = 100000000,
   parameter int Baud         = 9600,
   parameter int WordBytes    = 4,
   parameter int StopBits     = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   word_valid,
   output logic                   word_ready,
   input  logic [8*WordBytes-1:0] word_data,
   output logic                   TxD,
   output logic                   busy,
   output logic                   done
);

   localparam int CLKS_PER_BIT = clks_per_bit(ClkFrequency, Baud);

   if (CLKS_PER_BIT < 2) begin : gen_bad_rate
      $error("uart_word_tx: clock too slow for the requested baud rate");
   end
   if (WordBytes < 1 || WordBytes > 16) begin : gen_bad_bytes
      $error("uart_word_tx: WordBytes must be 1..16");
   end
   if (StopBits < 1 || StopBits > 2) begin : gen_bad_stop
      $error("uart_word_tx: StopBits must be 1..2");
   end

   logic                 accept;
   logic                 lastByte;
   logic [DATA_BITS-1:0] nextData;
   logic                 byteNext;
   logic                 busyInt;

   assign accept     = word_valid && !busyInt;
   assign word_ready = !busyInt;
   assign busy       = busyInt;

   if (WordBytes > 1) begin : gen_multi
      localparam int IDX_W = $clog2(WordBytes);
      localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WordBytes - 1);

      logic [8*WordBytes-1:0] wordReg;
      logic [IDX_W-1:0]       byteIdx;
      logic [IDX_W-1:0]       nextIdx;
      logic [DATA_BITS-1:0]   byteLane [WordBytes];

      for (genvar gi = 0; gi < WordBytes; gi++) begin : gen_lane
         assign byteLane[gi] = wordReg[8*gi +: 8];
      end

      // byteIdx names the byte currently on the line; byteNext arrives one
      // cycle after a chained byte starts, long before its stop bits end.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wordReg <= '0;
            byteIdx <= '0;
         end else if (accept) begin
            wordReg <= word_data;
            byteIdx <= '0;
         end else if (byteNext) begin
            byteIdx <= byteIdx + IDX_W'(1);
         end
      end

      assign lastByte = (byteIdx == IDX_LAST);
      assign nextIdx  = lastByte ? '0 : byteIdx + IDX_W'(1);
      assign nextData = byteLane[nextIdx];
   end else begin : gen_single
      assign lastByte = 1'b1;
      assign nextData = '0;
   end

   uart_byte_tx #(
      .ClksPerBit (CLKS_PER_BIT),
      .StopBits   (StopBits)
   ) byteTx (
      .clk       (clk),
      .rst       (rst),
      .byteStart (accept),
      .byteData  (word_data[7:0]),
      .lastByte  (lastByte),
      .nextData  (nextData),
      .byteNext  (byteNext),
      .TxD       (TxD),
      .busy      (busyInt),
      .done      (done)
   );

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Main instance: 40 Hz / 10 baud -> 4 clocks per bit, 4 bytes, 2 stop bits
   logic        wordValid = 1'b0;
   logic        wordReady;
   logic [31:0] wordData = '0;
   logic        txd, busy, done;

   // Single byte, 1 stop bit
   logic        wordValidB = 1'b0;
   logic        wordReadyB;
   logic [7:0]  wordDataB = '0;
   logic        txdB, busyB, doneB;

   // Real rate: 100 MHz / 9600 baud
   logic        wordValidC = 1'b0;
   logic        wordReadyC;
   logic [31:0] wordDataC = '0;
   logic        txdC, busyC, doneC;

   int checkCnt = 0;
   int errCnt   = 0;

   always #5 clk = ~clk;

   uart_word_tx #(.ClkFrequency(40), .Baud(10), .WordBytes(4), .StopBits(2)) dut (
      .clk(clk), .rst(rst), .word_valid(wordValid), .word_ready(wordReady),
      .word_data(wordData), .TxD(txd), .busy(busy), .done(done));

   uart_word_tx #(.ClkFrequency(40), .Baud(10), .WordBytes(1), .StopBits(1)) dutB (
      .clk(clk), .rst(rst), .word_valid(wordValidB), .word_ready(wordReadyB),
      .word_data(wordDataB), .TxD(txdB), .busy(busyB), .done(doneB));

   uart_word_tx #(.ClkFrequency(100000000), .Baud(9600), .WordBytes(4), .StopBits(2)) dutC (
      .clk(clk), .rst(rst), .word_valid(wordValidC), .word_ready(wordReadyC),
      .word_data(wordDataC), .TxD(txdC), .busy(busyC), .done(doneC));

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at the negedge right after acceptance edge N; returns at the
   // negedge after edge N+176 (word end for 4 bytes x 11 bits x 4 clocks).
   task automatic decodeWord(input logic [31:0] expWord);
      logic [43:0] bits;
      checkVal("acc_txd", 32'(txd), 32'd0);
      checkVal("acc_busy", 32'(busy), 32'd1);
      checkVal("acc_ready", 32'(wordReady), 32'd0);
      repeat (2) @(negedge clk);
      for (int j = 0; j < 44; j++) begin
         bits[j] = txd;
         if (j < 43) repeat (4) @(negedge clk);
      end
      for (int b = 0; b < 4; b++) begin
         checkVal($sformatf("b%0d_start", b), 32'(bits[11*b]), 32'd0);
         checkVal($sformatf("b%0d_data", b), 32'(bits[11*b+1 +: 8]), 32'(expWord[8*b +: 8]));
         checkVal($sformatf("b%0d_stop", b), 32'(bits[11*b+9 +: 2]), 32'd3);
      end
      @(negedge clk);
      checkVal("pre_done", 32'(done), 32'd0);
      checkVal("pre_busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkVal("end_done", 32'(done), 32'd1);
      checkVal("end_busy", 32'(busy), 32'd0);
      checkVal("end_ready", 32'(wordReady), 32'd1);
      checkVal("end_txd", 32'(txd), 32'd1);
      $display("word %h sent, %0d checks so far", expWord, checkCnt);
   endtask

   initial begin
      logic [9:0] bitsB;
      int         cnt;
      bit sawDone, sawLow, sawBusy, sawNotReady;

      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      checkVal("rst_txd", 32'(txd), 32'd1);
      checkVal("rst_busy", 32'(busy), 32'd0);
      checkVal("rst_ready", 32'(wordReady), 32'd1);
      checkVal("rst_done", 32'(done), 32'd0);

      // Idle 50 cycles
      sawDone = 0; sawLow = 0; sawBusy = 0; sawNotReady = 0;
      repeat (50) begin
         @(negedge clk);
         if (done) sawDone = 1;
         if (!txd) sawLow = 1;
         if (busy) sawBusy = 1;
         if (!wordReady) sawNotReady = 1;
      end
      checkVal("idle_done", 32'(sawDone), 32'd0);
      checkVal("idle_txdlow", 32'(sawLow), 32'd0);
      checkVal("idle_busy", 32'(sawBusy), 32'd0);
      checkVal("idle_notready", 32'(sawNotReady), 32'd0);
      $display("idle 50 cycles observed");

      // Single word
      wordData = 32'h44332211; wordValid = 1'b1;
      @(negedge clk);
      wordValid = 1'b0;
      decodeWord(32'h44332211);
      @(negedge clk);
      checkVal("after_done", 32'(done), 32'd0);

      // Back to back with valid held high; data changes while busy
      wordData = 32'hA5A5A5A5; wordValid = 1'b1;
      @(negedge clk);
      wordData = 32'h0000FFFF;
      decodeWord(32'hA5A5A5A5);
      @(negedge clk);
      wordValid = 1'b0; wordData = 32'hDEADBEEF;
      checkVal("b2b_done_clear", 32'(done), 32'd0);
      decodeWord(32'h0000FFFF);
      @(negedge clk);
      checkVal("b2b_no_third_txd", 32'(txd), 32'd1);
      checkVal("b2b_no_third_busy", 32'(busy), 32'd0);

      // Reset during data bit 3 of byte 2 (line bit 26, mid-bit at N+106)
      wordData = 32'h00000000; wordValid = 1'b1;
      @(negedge clk);
      wordValid = 1'b0;
      repeat (106) @(negedge clk);
      checkVal("mid_txd_low", 32'(txd), 32'd0);
      rst = 1'b1;
      #1;
      checkVal("arst_txd", 32'(txd), 32'd1);
      checkVal("arst_busy", 32'(busy), 32'd0);
      checkVal("arst_ready", 32'(wordReady), 32'd1);
      checkVal("arst_done", 32'(done), 32'd0);
      $display("async reset mid-frame applied");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wordData = 32'h01020304; wordValid = 1'b1;
      @(negedge clk);
      wordValid = 1'b0;
      decodeWord(32'h01020304);

      // One byte, one stop bit: 0x80 -> 0, 0000000, 1, 1 ; done at N+40
      wordDataB = 8'h80; wordValidB = 1'b1;
      @(negedge clk);
      wordValidB = 1'b0;
      checkVal("B_acc_txd", 32'(txdB), 32'd0);
      checkVal("B_acc_busy", 32'(busyB), 32'd1);
      repeat (2) @(negedge clk);
      for (int j = 0; j < 10; j++) begin
         bitsB[j] = txdB;
         if (j < 9) repeat (4) @(negedge clk);
      end
      checkVal("B_frame", 32'(bitsB), 32'h300);
      @(negedge clk);
      checkVal("B_pre_done", 32'(doneB), 32'd0);
      @(negedge clk);
      checkVal("B_done", 32'(doneB), 32'd1);
      checkVal("B_busy", 32'(busyB), 32'd0);
      @(negedge clk);
      checkVal("B_done_once", 32'(doneB), 32'd0);
      $display("byte 80 sent on single-byte instance");

      // Real rate: bit time 10417 cycles
      wordDataC = 32'h00000001; wordValidC = 1'b1;
      @(negedge clk);
      wordValidC = 1'b0;
      cnt = 0;
      while (txdC == 1'b0 && cnt < 20000) begin
         cnt++;
         @(negedge clk);
      end
      checkVal("C_start_len", 32'(cnt), 32'd10417);
      cnt = 0;
      while (txdC == 1'b1 && cnt < 20000) begin
         cnt++;
         @(negedge clk);
      end
      checkVal("C_bit0_len", 32'(cnt), 32'd10417);
      $display("real-rate bit length measured");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
      $finish;
   end

endmodule
